regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_mp.sv | 124 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared defaults and typedefs for the multi-ported register file.
//   NUM_RD_DEF / NUM_WR_DEF : default read / write port counts
//   REG_NUM_DEF             : default architectural register count
//   DATA_WIDTH_DEF          : default register width
//   reg_addr_t / reg_data_t : register index / data types at the default sizes
package regfile_pkg;

    localparam int NUM_RD_DEF     = 2;
    localparam int NUM_WR_DEF     = 2;
    localparam int REG_NUM_DEF    = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int AW_DEF         = (REG_NUM_DEF > 1) ? $clog2(REG_NUM_DEF) : 1;

    typedef logic [AW_DEF-1:0]         reg_addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// One busy bit per register: set on producer issue, cleared by any enabled
// write, wiped by flush. Query ports return the registered busy bit.
//   clk, reset         : clock, async active-high reset
//   set_en, set_addr   : mark a register busy at the next edge
//   clr_en, clr_addr   : per write port, clear busy at the next edge
//   flush              : clear every busy bit at the next edge
//   q_addr, q_busy     : per read port busy query (registered value)
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int  NUM_RD  = NUM_RD_DEF,
    parameter int  NUM_WR  = NUM_WR_DEF,
    parameter int  REG_NUM = REG_NUM_DEF,
    localparam int AW      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set_en,
    input  logic [AW-1:0]              set_addr,
    input  logic [NUM_WR-1:0]          clr_en,
    input  logic [NUM_WR-1:0][AW-1:0]  clr_addr,
    input  logic                       flush,
    input  logic [NUM_RD-1:0][AW-1:0]  q_addr,
    output logic [NUM_RD-1:0]          q_busy
);

    localparam logic [AW:0] REG_LIMIT = (AW+1)'(REG_NUM);

    // Register 0 and indices past the end of the file never hold a busy bit.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < REG_LIMIT);
    endfunction

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    // Clears are applied first so a same-cycle set on the same register wins;
    // flush overrides both.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (clr_en[p] && addr_ok(clr_addr[p])) begin
                busy_d[clr_addr[p]] = 1'b0;
            end
        end
        if (set_en && addr_ok(set_addr)) begin
            busy_d[set_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        q_busy = '0;
        for (int q = 0; q < NUM_RD; q++) begin
            if (addr_ok(q_addr[q])) begin
                q_busy[q] = busy_q[q_addr[q]];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-ported register file with zero-latency reads, same-cycle write
// bypass and a busy-bit scoreboard. Register 0 is hardwired to zero.
//   clk, reset                : clock, async active-high reset
//   r_en, r_addr              : per read port enable and index
//   r_data, r_busy            : per read port data and outstanding-producer flag
//   w_en, w_addr, w_data      : per write port enable, index, data
//   sb_set_en, sb_set_addr    : mark a register busy (producer issue)
//   flush                     : clear all busy bits
module regfile_mp import regfile_pkg::*; #(
    parameter int  NUM_RD     = NUM_RD_DEF,
    parameter int  NUM_WR     = NUM_WR_DEF,
    parameter int  REG_NUM    = REG_NUM_DEF,
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int AW         = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_RD-1:0]                  r_en,
    input  logic [NUM_RD-1:0][AW-1:0]          r_addr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  r_data,
    output logic [NUM_RD-1:0]                  r_busy,
    input  logic [NUM_WR-1:0]                  w_en,
    input  logic [NUM_WR-1:0][AW-1:0]          w_addr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]  w_data,
    input  logic                               sb_set_en,
    input  logic [AW-1:0]                      sb_set_addr,
    input  logic                               flush
);

    localparam logic [AW:0] REG_LIMIT = (AW+1)'(REG_NUM);

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < REG_LIMIT);
    endfunction

    logic [DATA_WIDTH-1:0]              mem [REG_NUM];
    logic [NUM_WR-1:0]                  w_ok;
    logic [REG_NUM-1:0]                 wr_hit;
    logic [DATA_WIDTH-1:0]              wr_val [REG_NUM];
    logic [NUM_RD-1:0]                  byp_hit;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]  byp_val;
    logic [NUM_RD-1:0]                  q_busy;

    always_comb begin
        w_ok = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            w_ok[p] = w_en[p] && addr_ok(w_addr[p]);
        end
    end

    // Ascending port scan: the last match, i.e. the highest-numbered port, wins.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            wr_val[i] = '0;
        end
        for (int i = 0; i < REG_NUM; i++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_ok[p] && (w_addr[p] == AW'(i))) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = w_data[p];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (wr_hit[i]) begin
                    mem[i] <= wr_val[i];
                end
            end
        end
    end

    always_comb begin
        byp_hit = '0;
        byp_val = '0;
        for (int q = 0; q < NUM_RD; q++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_ok[p] && (w_addr[p] == r_addr[q])) begin
                    byp_hit[q] = 1'b1;
                    byp_val[q] = w_data[p];
                end
            end
        end
    end

    // Reset masks the bypass path too, so reads are zero for the whole time
    // reset is high even while writes are still being presented.
    always_comb begin
        r_data = '0;
        r_busy = '0;
        for (int q = 0; q < NUM_RD; q++) begin
            if (!reset && r_en[q] && addr_ok(r_addr[q])) begin
                r_data[q] = byp_hit[q] ? byp_val[q] : mem[r_addr[q]];
                r_busy[q] = q_busy[q] && !byp_hit[q];
            end
        end
    end

    regfile_scoreboard #(
        .NUM_RD  (NUM_RD),
        .NUM_WR  (NUM_WR),
        .REG_NUM (REG_NUM)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (sb_set_en),
        .set_addr (sb_set_addr),
        .clr_en   (w_en),
        .clr_addr (w_addr),
        .flush    (flush),
        .q_addr   (r_addr),
        .q_busy   (q_busy)
    );

endmodule
